// File: rtl/pulse_tx_frame_scheduler.sv
// pulse_tx_frame_scheduler: queues transmit frames and sequences the pulse transmitter through them
//
// Ports:
//   clk, rst_n               project clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    frame command handshake into the FIFO (ready = not full)
//   cmd_end_count            program end count of the offered frame
//   cmd_loopback_count       program loopback count of the offered frame
//   cmd_repeat               extra runs of the frame (N gives N+1 runs)
//   cmd_gap                  idle cycles after each run
//   abort                    one-cycle pulse: stop, flush the queue, return to IDLE
//   tx_done                  one-cycle pulse from the transmitter at the end of a run
//   tx_start                 transmitter start level (acts on its rising edge)
//   tx_end_count             end count of the active frame
//   tx_loopback_count        loopback count of the active frame
//   busy                     scheduler is not IDLE
//   queue_level              FIFO occupancy
//   irq_en / irq_clear       interrupt enables and write-1-to-clear pulses
//   irq_status               bit0 frame_done, bit1 queue_drained (sticky)
//   irq                      any enabled status bit set
module pulse_tx_frame_scheduler #(
   parameter int QUEUE_DEPTH = 4,
   parameter int GAP_WIDTH   = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [6:0]                           cmd_end_count,
   input  logic [6:0]                           cmd_loopback_count,
   input  logic [3:0]                           cmd_repeat,
   input  logic [GAP_WIDTH-1:0]                 cmd_gap,
   input  logic                                 abort,
   input  logic                                 tx_done,
   output logic                                 tx_start,
   output logic [6:0]                           tx_end_count,
   output logic [6:0]                           tx_loopback_count,
   output logic                                 busy,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]     queue_level,
   input  logic [1:0]                           irq_en,
   input  logic [1:0]                           irq_clear,
   output logic [1:0]                           irq_status,
   output logic                                 irq
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = $clog2(QUEUE_DEPTH+1);
   localparam int EW = 18 + GAP_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t                 r_state, w_state_nxt;
   logic [EW-1:0]          r_mem [QUEUE_DEPTH];
   logic [AW-1:0]          r_wr, r_rd;
   logic [CW-1:0]          r_count;
   logic                   r_tx_start, w_start_nxt;
   logic [6:0]             r_end, r_loop;
   logic [3:0]             r_rep;
   logic [GAP_WIDTH-1:0]   r_gap, r_gap_cnt;
   logic [1:0]             r_irq, w_set;
   logic                   w_full, w_push, w_pop;
   logic                   w_gap_load, w_gap_dec, w_rep_dec;
   logic [EW-1:0]          w_head;

   assign w_full = r_count == CW'(QUEUE_DEPTH);
   assign cmd_ready = !w_full;
   // abort discards any command offered in the same cycle
   assign w_push = cmd_valid && !w_full && !abort;
   assign w_pop = r_state == IDLE && r_count != '0 && !abort;
   assign w_head = r_mem[r_rd];

   assign tx_start          = r_tx_start;
   assign tx_end_count      = r_end;
   assign tx_loopback_count = r_loop;
   assign busy              = r_state != IDLE;
   assign queue_level       = r_count;
   assign irq_status        = r_irq;
   assign irq               = |(r_irq & irq_en);

   always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = r_tx_start;
      w_gap_load  = 1'b0;
      w_gap_dec   = 1'b0;
      w_rep_dec   = 1'b0;
      w_set       = 2'b00;
      if (abort) begin
         w_state_nxt = IDLE;
         w_start_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  w_state_nxt = RUN;
                  w_start_nxt = 1'b1;
               end
            end
            RUN: begin
               if (tx_done) begin
                  w_state_nxt = GAP;
                  w_start_nxt = 1'b0;
                  w_gap_load  = 1'b1;
                  w_set[0]    = r_rep == 4'd0;
               end
            end
            GAP: begin
               if (r_gap_cnt != '0) begin
                  w_gap_dec = 1'b1;
               end else if (r_rep != 4'd0) begin
                  w_rep_dec   = 1'b1;
                  w_state_nxt = RUN;
                  w_start_nxt = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_set[1]    = r_count == '0;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_start_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= {cmd_end_count, cmd_loopback_count, cmd_repeat, cmd_gap};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tx_start <= 1'b0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_end      <= '0;
         r_loop     <= '0;
         r_rep      <= '0;
         r_gap      <= '0;
         r_gap_cnt  <= '0;
         r_irq      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx_start <= w_start_nxt;
         // a set in the same cycle as its clear wins
         r_irq      <= (r_irq & ~irq_clear) | w_set;
         if (abort) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_rep   <= '0;
         end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_pop) begin
               r_end  <= w_head[EW-1 -: 7];
               r_loop <= w_head[EW-8 -: 7];
               r_rep  <= w_head[GAP_WIDTH +: 4];
               r_gap  <= w_head[GAP_WIDTH-1:0];
            end else if (w_rep_dec) begin
               r_rep <= r_rep - 4'd1;
            end
            if (w_gap_load) r_gap_cnt <= r_gap;
            else if (w_gap_dec) r_gap_cnt <= r_gap_cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pulse_tx_frame_scheduler.sv
// tb_pulse_tx_frame_scheduler: directed self-checking bench for pulse_tx_frame_scheduler
module tb_pulse_tx_frame_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [6:0]  cmd_end_count = '0;
   logic [6:0]  cmd_loopback_count = '0;
   logic [3:0]  cmd_repeat = '0;
   logic [15:0] cmd_gap = '0;
   logic        abort = 1'b0;
   logic        tx_done = 1'b0;
   logic        tx_start;
   logic [6:0]  tx_end_count;
   logic [6:0]  tx_loopback_count;
   logic        busy;
   logic [2:0]  queue_level;
   logic [1:0]  irq_en = '0;
   logic [1:0]  irq_clear = '0;
   logic [1:0]  irq_status;
   logic        irq;
   int          checks = 0;
   int          failures = 0;
   int          rises = 0;
   int          rises0;
   logic        prev_start = 1'b0;

   pulse_tx_frame_scheduler dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_end_count(cmd_end_count), .cmd_loopback_count(cmd_loopback_count),
      .cmd_repeat(cmd_repeat), .cmd_gap(cmd_gap), .abort(abort), .tx_done(tx_done),
      .tx_start(tx_start), .tx_end_count(tx_end_count), .tx_loopback_count(tx_loopback_count),
      .busy(busy), .queue_level(queue_level), .irq_en(irq_en), .irq_clear(irq_clear),
      .irq_status(irq_status), .irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_start === 1'b1 && prev_start !== 1'b1) rises++;
      prev_start = tx_start;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [6:0] e, input logic [6:0] l, input logic [3:0] r, input logic [15:0] g);
      cmd_valid = 1'b1;
      cmd_end_count = e;
      cmd_loopback_count = l;
      cmd_repeat = r;
      cmd_gap = g;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", queue_level, 0);
      chk("rst_status", irq_status, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_end", tx_end_count, 0);
      chk("rst_loop", tx_loopback_count, 0);
      chk("rst_irq", irq, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);

      // single frame, gap 3
      offer(7'd5, 7'd0, 4'd0, 16'd3);
      step(1);
      cmd_valid = 1'b0;
      chk("sf_level_c1", queue_level, 1);
      chk("sf_start_c1", tx_start, 0);
      step(1);
      chk("sf_start_c2", tx_start, 1);
      chk("sf_end_c2", tx_end_count, 5);
      chk("sf_busy_c2", busy, 1);
      chk("sf_level_c2", queue_level, 0);
      step(38);
      chk("sf_start_c40", tx_start, 1);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      chk("sf_start_c41", tx_start, 0);
      chk("sf_status_c41", irq_status, 2'b01);
      step(3);
      chk("sf_busy_c44", busy, 1);
      chk("sf_status_c44", irq_status, 2'b01);
      step(1);
      chk("sf_busy_c45", busy, 0);
      chk("sf_status_c45", irq_status, 2'b11);
      irq_clear = 2'b11;
      step(1);
      irq_clear = 2'b00;
      chk("clr_status", irq_status, 2'b00);

      // repeats: three runs, gap 0
      rises0 = rises;
      offer(7'd9, 7'd2, 4'd2, 16'd0);
      step(1);
      cmd_valid = 1'b0;
      step(1);
      chk("rp_start_c2", tx_start, 1);
      chk("rp_end_c2", tx_end_count, 9);
      chk("rp_loop_c2", tx_loopback_count, 2);
      for (int k = 0; k < 3; k++) begin
         step(18);
         tx_done = 1'b1;
         step(1);
         tx_done = 1'b0;
         chk("rp_low", tx_start, 0);
         chk("rp_status_after_done", irq_status, k == 2 ? 2'b01 : 2'b00);
         step(1);
         chk("rp_next", tx_start, k == 2 ? 0 : 1);
      end
      chk("rp_busy_end", busy, 0);
      chk("rp_status_end", irq_status, 2'b11);
      chk("rp_rises", rises - rises0, 3);
      irq_clear = 2'b11;
      step(1);
      irq_clear = 2'b00;

      // queue full while a frame runs
      offer(7'd10, 7'd1, 4'd0, 16'd1);
      step(1);
      cmd_valid = 1'b0;
      step(1);
      chk("qf_start", tx_start, 1);
      for (int k = 0; k < 4; k++) begin
         offer(7'(11 + k), 7'd0, 4'd0, 16'd1);
         step(1);
      end
      offer(7'd15, 7'd0, 4'd0, 16'd1);
      chk("qf_ready_full", cmd_ready, 0);
      chk("qf_level_full", queue_level, 4);
      step(1);
      cmd_valid = 1'b0;
      chk("qf_level_5th", queue_level, 4);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      chk("qf_start_gap", tx_start, 0);
      step(2);
      chk("qf_idle_busy", busy, 0);
      chk("qf_idle_level", queue_level, 4);
      chk("qf_idle_start", tx_start, 0);
      step(1);
      chk("qf_pop_ready", cmd_ready, 1);
      chk("qf_pop_level", queue_level, 3);
      chk("qf_pop_end", tx_end_count, 11);
      chk("qf_pop_start", tx_start, 1);
      for (int k = 0; k < 3; k++) begin
         tx_done = 1'b1;
         step(1);
         tx_done = 1'b0;
         step(3);
         chk("qf_order_end", tx_end_count, 12 + k);
         chk("qf_order_level", queue_level, 2 - k);
         chk("qf_order_start", tx_start, 1);
      end
      chk("qf_status", irq_status, 2'b01);

      // abort mid-RUN with two queued frames and a simultaneous offer
      offer(7'd20, 7'd0, 4'd0, 16'd0);
      step(1);
      offer(7'd21, 7'd0, 4'd0, 16'd0);
      step(1);
      chk("ab_level_pre", queue_level, 2);
      offer(7'd22, 7'd0, 4'd0, 16'd0);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      cmd_valid = 1'b0;
      chk("ab_start", tx_start, 0);
      chk("ab_level", queue_level, 0);
      chk("ab_busy", busy, 0);
      chk("ab_status", irq_status, 2'b01);
      chk("ab_end_hold", tx_end_count, 14);
      step(1);
      chk("ab_level_after", queue_level, 0);
      chk("ab_busy_after", busy, 0);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      chk("ab_done_busy", busy, 0);
      chk("ab_done_start", tx_start, 0);
      chk("ab_done_status", irq_status, 2'b01);

      // interrupts
      irq_clear = 2'b11;
      step(1);
      irq_clear = 2'b00;
      chk("ir_cleared", irq_status, 2'b00);
      irq_en = 2'b01;
      offer(7'd30, 7'd0, 4'd0, 16'd0);
      step(1);
      cmd_valid = 1'b0;
      step(1);
      chk("ir_irq_run", irq, 0);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      chk("ir_irq_done", irq, 1);
      step(1);
      chk("ir_status_drain", irq_status, 2'b11);
      offer(7'd31, 7'd0, 4'd0, 16'd0);
      step(1);
      cmd_valid = 1'b0;
      step(1);
      chk("ir_run2", tx_start, 1);
      tx_done = 1'b1;
      irq_clear = 2'b01;
      step(1);
      tx_done = 1'b0;
      irq_clear = 2'b00;
      chk("ir_set_wins", irq_status[0], 1);
      step(1);
      irq_clear = 2'b01;
      step(1);
      irq_clear = 2'b00;
      chk("ir_clear_status", irq_status, 2'b10);
      chk("ir_clear_irq", irq, 0);
      irq_en = 2'b10;
      #1;
      chk("ir_en_comb", irq, 1);

      // async reset mid-GAP with a frame still queued
      irq_en = 2'b11;
      offer(7'd40, 7'd3, 4'd0, 16'd5);
      step(1);
      offer(7'd41, 7'd0, 4'd0, 16'd0);
      step(1);
      cmd_valid = 1'b0;
      chk("rs_pushpop_level", queue_level, 1);
      chk("rs_start", tx_start, 1);
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
      step(1);
      chk("rs_gap_busy", busy, 1);
      rst_n = 1'b0;
      #2;
      chk("rs_start0", tx_start, 0);
      chk("rs_busy0", busy, 0);
      chk("rs_level0", queue_level, 0);
      chk("rs_status0", irq_status, 0);
      chk("rs_irq0", irq, 0);
      chk("rs_end0", tx_end_count, 0);
      chk("rs_loop0", tx_loopback_count, 0);
      chk("rs_ready0", cmd_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      chk("rs_after_start", tx_start, 0);
      chk("rs_after_busy", busy, 0);
      chk("rs_after_level", queue_level, 0);

      // async reset mid-RUN
      offer(7'd50, 7'd0, 4'd0, 16'd0);
      step(1);
      cmd_valid = 1'b0;
      step(1);
      chk("rr_start", tx_start, 1);
      rst_n = 1'b0;
      #2;
      chk("rr_start0", tx_start, 0);
      chk("rr_end0", tx_end_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pulse_tx_frame_scheduler.md
Name: pulse_tx_frame_scheduler

Overview:
- Sequences the pulse transmitter through a queue of transmit frames.
- Each frame is a program window (end count, loopback count), a repeat count and an inter-frame gap.
- Buffers frame commands from the TinyQV register interface in a small FIFO and drives the transmitter's start level and program-window configuration.
- Generates a level-sensitive interrupt on frame completion and on queue drain.

Parameters:
QUEUE_DEPTH, 4, command FIFO entries (power of 2, 2..8)
GAP_WIDTH, 16, width of the inter-frame gap counter in clk cycles

Ports:
clk  input  1  TinyQV project clock
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  frame command offered
cmd_ready  output  1  FIFO can accept (= not full)
cmd_end_count  input  7  program end count for the frame
cmd_loopback_count  input  7  program loopback count for the frame
cmd_repeat  input  4  extra transmissions (N gives N+1 runs)
cmd_gap  input  GAP_WIDTH  idle cycles after each run
abort  input  1  single-cycle pulse: stop and flush
tx_done  input  1  single-cycle pulse from transmitter: output returned to idle after end count
tx_start  output  1  transmitter start level (transmitter acts on its rising edge)
tx_end_count  output  7  active frame end count
tx_loopback_count  output  7  active frame loopback count
busy  output  1  state != IDLE
queue_level  output  $clog2(QUEUE_DEPTH+1)  FIFO occupancy
irq_en  input  2  interrupt enables
irq_clear  input  2  write-1-to-clear pulses
irq_status  output  2  bit0 frame_done, bit1 queue_drained (sticky)
irq  output  1  |(irq_status & irq_en)

Behaviour:
- Reset (async assert, sync deassert by the system) forces:
  - state=IDLE, FIFO empty, tx_start=0, tx_end_count=0, tx_loopback_count=0, busy=0, queue_level=0, irq_status=0.
  - cmd_ready=1 after reset.
- FIFO:
  - Push when cmd_valid && cmd_ready; queue_level updates the next cycle.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle leave queue_level unchanged.
  - cmd_ready is combinational !full; a pop at full cannot admit a push in the same cycle.
- FSM states: IDLE, RUN, GAP. All outputs are registered.
- IDLE:
  - If the FIFO is non-empty, pop the head.
  - Latch end/loopback into tx_* and repeat/gap into active registers (rep_left=cmd_repeat).
  - Next state RUN with tx_start<=1, so tx_start rises 1 cycle after the pop.
  - Push into an empty idle queue at cycle 0 gives pop at cycle 1 and tx_start=1 at cycle 2.
- RUN:
  - tx_start held at 1.
  - On tx_done: tx_start<=0, gap_cnt<=active gap, next state GAP.
  - If rep_left==0 at that edge, set irq_status[0] (frame_done) on the same edge.
- GAP:
  - tx_start=0.
  - If gap_cnt!=0, decrement.
  - If gap_cnt==0:
    - rep_left!=0: decrement rep_left, go RUN with tx_start<=1.
    - rep_left==0 and FIFO non-empty: go IDLE.
    - rep_left==0 and FIFO empty: go IDLE and set irq_status[1].
  - A gap of G yields exactly G+1 cycles of tx_start low before the next RUN.
  - Between frames there is one additional IDLE cycle, so the low time is G+2 cycles.
  - The guaranteed low cycle makes every run produce a fresh rising edge.
- tx_done outside RUN is ignored.
- abort, from any state:
  - Next cycle: state=IDLE, tx_start=0, FIFO flushed (queue_level=0), rep_left=0.
  - tx_* hold their last values.
  - No irq bits are set.
  - abort takes priority over push, pop and tx_done in the same cycle; a push in the abort cycle is discarded.
- Interrupts:
  - irq_status bits are sticky.
  - irq_clear[i] clears bit i; a set in the same cycle wins over the clear.
  - irq is combinational from registered status and irq_en.
- Reset mid-RUN drops tx_start immediately (async) and discards the queue.
- Widths: rep_left is 4 bits and never wraps (checked before decrement); gap_cnt is GAP_WIDTH bits, with a maximum gap of 2^GAP_WIDTH-1.

Test Plan:
- Single frame: push {end=5, loop=0, repeat=0, gap=3} into an empty idle queue at cycle 0 -> tx_start rises at cycle 2 with tx_end_count=5. Pulse tx_done at cycle 40 -> tx_start=0 from cycle 41, irq_status=01 at 41, state IDLE after 4 GAP cycles, irq_status=11, busy=0.
- Repeats: push {repeat=2, gap=0}, pulse tx_done three times spaced by 20 cycles -> exactly 3 tx_start rising edges, each preceded by exactly 1 low cycle, frame_done set only after the third tx_done.
- Queue full: push 5 commands back-to-back while a frame runs -> 4 accepted, cmd_ready=0 on the 5th, queue_level=4. After the next pop -> cmd_ready=1 and queue_level=3. Frames execute in FIFO order, checked on tx_end_count.
- Abort mid-RUN with 2 queued frames and simultaneous cmd_valid -> next cycle tx_start=0, queue_level=0, busy=0, irq_status unchanged. A later tx_done pulse causes no state change.
- Interrupt: irq_en=01, complete a frame -> irq=1. Assert irq_clear=01 in the same cycle as a new frame_done set -> bit stays 1. A clear alone -> irq=0.
- Async reset asserted mid-GAP -> all outputs reach reset values without a clock edge. After release, an empty queue keeps tx_start=0.
